// File: rtl/nand7_filt_pkg.sv
// nand7_filt_pkg: shared constants and helpers for the nand7_filt stage.
//   DEB_CYCLES_MAX / CNT_W_MAX : upper legal bounds of the top-level parameters
//   DEB_CYCLES_DEF / CNT_W_DEF : default parameter values
//   stab_width()               : width of the debounce counter for a given DEB_CYCLES
package nand7_filt_pkg;

  localparam int DEB_CYCLES_MAX = 255;
  localparam int CNT_W_MAX      = 32;
  localparam int DEB_CYCLES_DEF = 4;
  localparam int CNT_W_DEF      = 8;

  // The counter must be able to hold DEB_CYCLES-1; sized as $clog2(DEB_CYCLES+1)
  // so that DEB_CYCLES=1 still yields a 1-bit counter.
  function automatic int stab_width(input int deb_cycles);
    return $clog2(deb_cycles + 1);
  endfunction

endpackage

// File: rtl/nand7_filt_if.sv
// nand7_filt_if: condition/control/result bundle of the nand7_filt stage.
//   A0..A6 : condition inputs (asynchronous to CK unless the caller guarantees otherwise)
//   CE     : clock enable for debounce, output and counter logic
//   CLR    : synchronous clear of CNT
//   ZN0    : filtered NAND of A0..A6
//   FALL   : one-cycle pulse after ZN0 goes 1->0
//   CNT    : saturating count of ZN0 1->0 events
// Modports: master drives conditions/controls, slave is the filter itself.
interface nand7_filt_if
  import nand7_filt_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic             A0;
  logic             A1;
  logic             A2;
  logic             A3;
  logic             A4;
  logic             A5;
  logic             A6;
  logic             CE;
  logic             CLR;
  logic             ZN0;
  logic             FALL;
  logic [CNT_W-1:0] CNT;

  modport master (
    output A0, A1, A2, A3, A4, A5, A6, CE, CLR,
    input  ZN0, FALL, CNT
  );

  modport slave (
    input  A0, A1, A2, A3, A4, A5, A6, CE, CLR,
    output ZN0, FALL, CNT
  );

endinterface

// File: rtl/nand7_filt_sync.sv
// nand7_filt_sync: 7-bit two-flop synchronizer with asynchronous active-high reset.
//   clk : sampling clock
//   rst : asynchronous reset, clears both stages
//   d   : asynchronous inputs
//   q   : synchronized outputs (second stage)
// In the top the second stage doubles as the sample flop, so the synchronizer
// adds only one cycle of latency over the unsynchronized build.
module nand7_filt_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] d,
  output logic [6:0] q
);

  logic [6:0] meta;

  // Two-stage capture of the asynchronous condition inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 7'd0;
      q    <= 7'd0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nand7_filt.sv
// nand7_filt: registered, debounced 7-input NAND with fall-event pulse and counter.
//   CK  : clock, all state rising-edge
//   CD  : asynchronous active-high reset
//   bus : nand7_filt_if.slave (A0..A6, CE, CLR in; ZN0, FALL, CNT out)
// Parameters: DEB_CYCLES (1..255) consecutive mismatching cycles before ZN0 moves,
//             CNT_W (1..32) width of CNT.
// Build option: define NAND7_FILT_SYNC_EN to put a two-flop synchronizer in front
// of the sample flops (one extra cycle of latency).
module nand7_filt
  import nand7_filt_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input logic         CK,
  input logic         CD,
  nand7_filt_if.slave bus
);

  localparam int               STAB_W    = stab_width(DEB_CYCLES);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEB_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  // Parameter legality, checked once at elaboration.
  if (DEB_CYCLES < 1 || DEB_CYCLES > DEB_CYCLES_MAX) begin : g_deb_range
    $error("nand7_filt: DEB_CYCLES must be in 1..%0d", DEB_CYCLES_MAX);
  end
  if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_cnt_range
    $error("nand7_filt: CNT_W must be in 1..%0d", CNT_W_MAX);
  end

  logic [6:0]        a_in;
  logic [6:0]        s;
  logic              n_raw;
  logic              mismatch;
  logic              at_limit;
  logic              fall_evt;
  logic [STAB_W-1:0] stab;
  logic              zn0;
  logic              fall;
  logic [CNT_W-1:0]  cnt;

  assign a_in = {bus.A6, bus.A5, bus.A4, bus.A3, bus.A2, bus.A1, bus.A0};

`ifdef NAND7_FILT_SYNC_EN
  nand7_filt_sync u_sync (
    .clk (CK),
    .rst (CD),
    .d   (a_in),
    .q   (s)
  );
`else
  // Sample flop; inputs are assumed synchronous to CK in this build.
  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      s <= 7'd0;
    end else begin
      s <= a_in;
    end
  end
`endif

  // Raw NAND and the decode of the debounce step; a fall event is the edge on
  // which ZN0 leaves 1 for 0, which only happens while CE is high.
  always_comb begin
    n_raw    = ~&s;
    mismatch = (n_raw != zn0);
    at_limit = (stab == STAB_LAST);
    fall_evt = bus.CE & mismatch & at_limit & zn0;
  end

  // Debounce counter, filtered output, fall pulse and event counter.
  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      stab <= '0;
      zn0  <= 1'b1;
      fall <= 1'b0;
      cnt  <= '0;
    end else begin
      if (bus.CE) begin
        if (!mismatch) begin
          stab <= '0;
        end else if (at_limit) begin
          zn0  <= n_raw;
          stab <= '0;
        end else begin
          stab <= stab + STAB_ONE;
        end
      end else begin
        stab <= stab;
      end

      fall <= fall_evt;

      // CLR overrides CE; a simultaneous event still counts as the first one.
      if (bus.CLR) begin
        cnt <= fall_evt ? CNT_ONE : '0;
      end else if (fall_evt && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_ONE;
      end else begin
        cnt <= cnt;
      end
    end
  end

  assign bus.ZN0  = zn0;
  assign bus.FALL = fall;
  assign bus.CNT  = cnt;

endmodule

// File: tb/tb_nand7_filt.sv
// tb_nand7_filt: directed bench for nand7_filt. Three instances share one
// stimulus: main (DEB_CYCLES=4, CNT_W=8), sat (DEB_CYCLES=4, CNT_W=2) and
// fast (DEB_CYCLES=1, CNT_W=8). Expected latencies follow NAND7_FILT_SYNC_EN.
module tb_nand7_filt;

`ifdef NAND7_FILT_SYNC_EN
  localparam int SYNC_LAT = 1;
`else
  localparam int SYNC_LAT = 0;
`endif
  // Number of rising edges, counting the sampling edge, until the output moves.
  localparam int LAT   = 4 + 1 + SYNC_LAT;
  localparam int LAT_F = 1 + 1 + SYNC_LAT;

  logic       ck;
  logic       cd;
  logic [6:0] a;
  logic       ce;
  logic       clr;

  int n_tests;
  int n_fail;
  int sat_exp [5];

  nand7_filt_if #(.CNT_W(8)) bus_main ();
  nand7_filt_if #(.CNT_W(2)) bus_sat ();
  nand7_filt_if #(.CNT_W(8)) bus_fast ();

  assign {bus_main.A6, bus_main.A5, bus_main.A4, bus_main.A3, bus_main.A2, bus_main.A1, bus_main.A0} = a;
  assign {bus_sat.A6, bus_sat.A5, bus_sat.A4, bus_sat.A3, bus_sat.A2, bus_sat.A1, bus_sat.A0} = a;
  assign {bus_fast.A6, bus_fast.A5, bus_fast.A4, bus_fast.A3, bus_fast.A2, bus_fast.A1, bus_fast.A0} = a;
  assign bus_main.CE  = ce;
  assign bus_sat.CE   = ce;
  assign bus_fast.CE  = ce;
  assign bus_main.CLR = clr;
  assign bus_sat.CLR  = clr;
  assign bus_fast.CLR = clr;

  nand7_filt #(.DEB_CYCLES(4), .CNT_W(8)) u_main (.CK(ck), .CD(cd), .bus(bus_main));
  nand7_filt #(.DEB_CYCLES(4), .CNT_W(2)) u_sat  (.CK(ck), .CD(cd), .bus(bus_sat));
  nand7_filt #(.DEB_CYCLES(1), .CNT_W(8)) u_fast (.CK(ck), .CD(cd), .bus(bus_fast));

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ck);
    end
    #1;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    sat_exp    = '{1, 2, 3, 3, 3};
    cd         = 1'b1;
    a          = 7'h7F;
    ce         = 1'b1;
    clr        = 1'b0;

    // Reset: values appear before any clock edge.
    #2;
    chk("rst_zn0", 32'(bus_main.ZN0), 32'd1);
    chk("rst_fall", 32'(bus_main.FALL), 32'd0);
    chk("rst_cnt", 32'(bus_main.CNT), 32'd0);
    chk("rst_fast_zn0", 32'(bus_fast.ZN0), 32'd1);
    tick(2);
    chk("rst_hold_zn0", 32'(bus_main.ZN0), 32'd1);

    // Release with all inputs high: fast falls first, main after LAT edges.
    cd = 1'b0;
    tick(LAT_F);
    chk("fast_zn0", 32'(bus_fast.ZN0), 32'd0);
    chk("fast_fall", 32'(bus_fast.FALL), 32'd1);
    chk("main_early", 32'(bus_main.ZN0), 32'd1);
    tick(LAT - LAT_F - 1);
    chk("main_edge_m1", 32'(bus_main.ZN0), 32'd1);
    chk("main_edge_m1_fall", 32'(bus_main.FALL), 32'd0);
    tick(1);
    chk("main_zn0", 32'(bus_main.ZN0), 32'd0);
    chk("main_fall", 32'(bus_main.FALL), 32'd1);
    chk("main_cnt", 32'(bus_main.CNT), 32'd1);
    chk("sat_cnt0", 32'(bus_sat.CNT), 32'd1);
    tick(1);
    chk("fall_once", 32'(bus_main.FALL), 32'd0);
    chk("cnt_hold", 32'(bus_main.CNT), 32'd1);

    // Rise back to 1: no pulse, no count.
    a = 7'h7E;
    tick(LAT - 1);
    chk("rise_early", 32'(bus_main.ZN0), 32'd0);
    tick(1);
    chk("rise_zn0", 32'(bus_main.ZN0), 32'd1);
    chk("rise_fall", 32'(bus_main.FALL), 32'd0);
    chk("rise_cnt", 32'(bus_main.CNT), 32'd1);

    // Glitch: all high for 3 sampled cycles, then A3 drops.
    a = 7'h7F;
    tick(3);
    a = 7'h77;
    for (int i = 0; i < LAT + 3; i++) begin
      tick(1);
      chk("glitch_zn0", 32'(bus_main.ZN0), 32'd1);
      chk("glitch_fall", 32'(bus_main.FALL), 32'd0);
    end
    chk("glitch_cnt", 32'(bus_main.CNT), 32'd1);

    // Clear, then five full fall/rise cycles; sat saturates at 3.
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_cnt", 32'(bus_main.CNT), 32'd0);
    chk("clr_sat_cnt", 32'(bus_sat.CNT), 32'd0);
    for (int i = 0; i < 5; i++) begin
      a = 7'h7F;
      tick(LAT);
      chk("sat_fall", 32'(bus_main.FALL), 32'd1);
      chk("sat_main_cnt", 32'(bus_main.CNT), 32'(i + 1));
      chk("sat_cnt", 32'(bus_sat.CNT), 32'(sat_exp[i]));
      a = 7'h7E;
      tick(LAT);
    end

    // CLR on the same edge as a fall event.
    a = 7'h7F;
    tick(LAT - 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("coll_cnt", 32'(bus_main.CNT), 32'd1);
    chk("coll_sat_cnt", 32'(bus_sat.CNT), 32'd1);
    chk("coll_fall", 32'(bus_main.FALL), 32'd1);
    a = 7'h7E;
    tick(LAT);
    chk("coll_rise", 32'(bus_main.ZN0), 32'd1);

    // CE low for 10 cycles with stab at 2; two edges to finish after CE returns.
    a = 7'h7F;
    tick(LAT - 2);
    ce = 1'b0;
    tick(10);
    chk("ce_hold_zn0", 32'(bus_main.ZN0), 32'd1);
    chk("ce_hold_fall", 32'(bus_main.FALL), 32'd0);
    ce = 1'b1;
    tick(1);
    chk("ce_ret1_zn0", 32'(bus_main.ZN0), 32'd1);
    tick(1);
    chk("ce_ret2_zn0", 32'(bus_main.ZN0), 32'd0);
    chk("ce_ret2_fall", 32'(bus_main.FALL), 32'd1);
    chk("ce_ret2_cnt", 32'(bus_main.CNT), 32'd2);

    // Toggling mismatch keeps resetting stab, ZN0 never moves.
    for (int i = 0; i < 20; i++) begin
      a = (i % 2 == 0) ? 7'h7E : 7'h7F;
      tick(1);
      chk("toggle_zn0", 32'(bus_main.ZN0), 32'd0);
    end

    // Reset mid-debounce forces ZN0 high without a clock edge.
    a = 7'h7E;
    tick(2);
    cd = 1'b1;
    #1;
    chk("cd_zn0", 32'(bus_main.ZN0), 32'd1);
    chk("cd_cnt", 32'(bus_main.CNT), 32'd0);
    chk("cd_sat_cnt", 32'(bus_sat.CNT), 32'd0);
    a = 7'h7F;
    tick(2);
    cd = 1'b0;
    tick(LAT - 1);
    chk("post_cd_early", 32'(bus_main.ZN0), 32'd1);
    tick(1);
    chk("post_cd_zn0", 32'(bus_main.ZN0), 32'd0);
    chk("post_cd_cnt", 32'(bus_main.CNT), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
